sys_pe: RTL and testbench

//  Parametrised systolic-array processing element (next-gen multiply-accumulate tile cell).

---
 rtl/sys_pe.sv | 76 +++++++
 tb/tb_sys_pe.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sys_pe.sv
// sys_pe: systolic MAC cell that forwards A east and B south, accumulates one dot product per tile,
// and holds the tile result in a register that drains down the column's shift chain.
module sys_pe #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_valid_in,
  input  logic              a_first_in,
  input  logic              a_last_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_valid_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_valid_out,
  output logic              a_first_out,
  output logic              a_last_out,
  output logic [DATA_W-1:0] b_out,
  output logic              b_valid_out,
  input  logic              shift_en,
  input  logic [ACC_W-1:0]  res_in,
  input  logic              res_valid_in,
  output logic [ACC_W-1:0]  res_out,
  output logic              res_valid,
  output logic              ovf,
  output logic              err
);
  localparam int PW = 2 * DATA_W;
  logic [DATA_W-1:0] r_a, r_b;
  logic              r_av, r_af, r_al, r_bv, r_rv, r_ovf, r_err;
  logic [ACC_W-1:0]  r_acc, r_res;
  logic signed [PW-1:0] w_prod_s;
  logic [PW-1:0]     w_prod_u;
  logic [ACC_W:0]    w_prod_x, w_base, w_sum_x;
  logic [ACC_W-1:0]  w_clamp, w_sum;
  logic              w_fire, w_ovf, w_lfire;
  assign w_prod_s = PW'($signed(a_in)) * PW'($signed(b_in));
  assign w_prod_u = PW'(a_in) * PW'(b_in);
  assign w_prod_x = SIGNED != 0 ? {{(ACC_W + 1 - PW){w_prod_s[PW-1]}}, w_prod_s}
                                : {{(ACC_W + 1 - PW){1'b0}}, w_prod_u};
  assign w_base   = a_first_in ? '0 : {SIGNED != 0 ? r_acc[ACC_W-1] : 1'b0, r_acc};
  // One guard bit above ACC_W exposes both signed and unsigned overflow
  assign w_sum_x  = w_base + w_prod_x;
  assign w_ovf    = SIGNED != 0 ? w_sum_x[ACC_W] ^ w_sum_x[ACC_W-1] : w_sum_x[ACC_W];
  assign w_clamp  = SIGNED == 0 ? {ACC_W{1'b1}}
                  : w_sum_x[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
  assign w_sum    = (SATURATE != 0 && w_ovf) ? w_clamp : w_sum_x[ACC_W-1:0];
  assign w_fire   = a_valid_in & b_valid_in;
  assign w_lfire  = w_fire & a_last_in;
  always_ff @(posedge CLK) begin
    if (rst) begin
      {r_a, r_b, r_av, r_af, r_al, r_bv} <= '0;
      {r_acc, r_res, r_rv, r_ovf, r_err} <= '0;
    end else begin
      {r_a, r_av, r_af, r_al} <= {a_in, a_valid_in, a_first_in, a_last_in};
      {r_b, r_bv}             <= {b_in, b_valid_in};
      if (w_fire) r_acc <= a_last_in ? '0 : w_sum;
      if (w_fire & w_ovf) r_ovf <= 1'b1;
      if ((a_valid_in ^ b_valid_in) | (w_lfire & shift_en)) r_err <= 1'b1;
      // A finishing tile owns the result register even while the column drains
      if (w_lfire) begin
        r_res <= w_sum;
        r_rv  <= 1'b1;
      end else if (shift_en) begin
        r_res <= res_in;
        r_rv  <= res_valid_in;
      end
    end
  end
  assign {a_out, a_valid_out, a_first_out, a_last_out} = {r_a, r_av, r_af, r_al};
  assign {b_out, b_valid_out}                          = {r_b, r_bv};
  assign {res_out, res_valid, ovf, err}                = {r_res, r_rv, r_ovf, r_err};
endmodule

// File: tb/tb_sys_pe.sv
// tb_sys_pe: directed checks of four sys_pe flavours driven by one shared stimulus stream.
module tb_sys_pe;
  logic        CLK = 1'b0;
  logic        rst;
  logic [7:0]  a_in, b_in;
  logic        av, af, al, bv, se, rvi;
  logic [23:0] res_in;
  logic [7:0]  a_o [4];
  logic [7:0]  b_o [4];
  logic        avo [4];
  logic        afo [4];
  logic        alo [4];
  logic        bvo [4];
  logic        rv  [4];
  logic        ovf [4];
  logic        err [4];
  logic [23:0] res_w [4];
  int          total = 0;
  int          passed = 0;
  int          fails = 0;
  always #5 CLK = ~CLK;
  // 0: unsigned/24b, 1: signed/24b/sat, 2: signed/16b/sat, 3: signed/16b/wrap
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int AW = g < 2 ? 24 : 16;
    logic [AW-1:0] r;
    sys_pe #(.DATA_W(8), .ACC_W(AW), .SIGNED(g != 0), .SATURATE(g != 3)) u_pe (
      .CLK(CLK), .rst(rst),
      .a_in(a_in), .a_valid_in(av), .a_first_in(af), .a_last_in(al),
      .b_in(b_in), .b_valid_in(bv),
      .a_out(a_o[g]), .a_valid_out(avo[g]), .a_first_out(afo[g]), .a_last_out(alo[g]),
      .b_out(b_o[g]), .b_valid_out(bvo[g]),
      .shift_en(se), .res_in(res_in[AW-1:0]), .res_valid_in(rvi),
      .res_out(r), .res_valid(rv[g]), .ovf(ovf[g]), .err(err[g])
    );
    assign res_w[g] = 24'(r);
  end
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic va, input logic vb,
                       input logic f, input logic l);
    a_in = a; b_in = b; av = va; bv = vb; af = f; al = l;
  endtask
  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_res(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                         input logic [23:0] e2, input logic [23:0] e3);
    chk({tag, "_u24"}, res_w[0], e0);
    chk({tag, "_s24"}, res_w[1], e1);
    chk({tag, "_sat16"}, res_w[2], e2);
    chk({tag, "_wrap16"}, res_w[3], e3);
  endtask
  task automatic chk_zero_state(input string tag);
    for (int g = 0; g < 4; g++) begin
      chk({tag, "_res"}, res_w[g], 24'd0);
      chk({tag, "_rv"}, 24'(rv[g]), 24'd0);
      chk({tag, "_err"}, 24'(err[g]), 24'd0);
      chk({tag, "_ovf"}, 24'(ovf[g]), 24'd0);
      chk({tag, "_avo"}, 24'(avo[g]), 24'd0);
      chk({tag, "_a_out"}, 24'(a_o[g]), 24'd0);
    end
  endtask
  initial begin
    rst = 1'b1; se = 1'b0; rvi = 1'b0; res_in = '0;
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    tick;
    chk_zero_state("reset");
    rst = 1'b0;
    drive(8'd3, 8'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    tick;
    chk("fwd_a", 24'(a_o[1]), 24'd3);
    chk("fwd_av", 24'(avo[1]), 24'd1);
    chk("fwd_af", 24'(afo[1]), 24'd1);
    chk("fwd_al", 24'(alo[1]), 24'd0);
    chk("no_res_yet", 24'(rv[0]), 24'd0);
    drive(8'd5, 8'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    tick;
    chk_res("dot42", 24'd42, 24'd42, 24'd42, 24'd42);
    for (int g = 0; g < 4; g++) chk("dot42_rv", 24'(rv[g]), 24'd1);
    chk("fwd_b", 24'(b_o[0]), 24'd6);
    chk("fwd_bv", 24'(bvo[0]), 24'd1);
    chk("fwd_al_last", 24'(alo[2]), 24'd1);
    drive(8'hFE, 8'd7, 1'b1, 1'b1, 1'b1, 1'b1);
    tick;
    chk_res("neg", 24'h0006F2, 24'hFFFFF2, 24'h00FFF2, 24'h00FFF2);
    chk("neg_a_out", 24'(a_o[1]), 24'h0000FE);
    chk("neg_avo", 24'(avo[1]), 24'd1);
    for (int g = 0; g < 4; g++) chk("neg_ovf", 24'(ovf[g]), 24'd0);
    drive(8'd127, 8'd127, 1'b1, 1'b1, 1'b1, 1'b0);
    tick;
    drive(8'd127, 8'd127, 1'b1, 1'b1, 1'b0, 1'b0);
    tick;
    drive(8'd127, 8'd127, 1'b1, 1'b1, 1'b0, 1'b1);
    tick;
    chk_res("sat", 24'h00BD03, 24'h00BD03, 24'h007FFF, 24'h00BD03);
    chk("sat_ovf_u24", 24'(ovf[0]), 24'd0);
    chk("sat_ovf_s24", 24'(ovf[1]), 24'd0);
    chk("sat_ovf_sat16", 24'(ovf[2]), 24'd1);
    chk("sat_ovf_wrap16", 24'(ovf[3]), 24'd1);
    drive(8'd2, 8'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    tick;
    drive(8'd1, 8'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick;
    chk_res("tileA", 24'd7, 24'd7, 24'd7, 24'd7);
    drive(8'd4, 8'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    tick;
    chk_res("hold", 24'd7, 24'd7, 24'd7, 24'd7);
    drive(8'd1, 8'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    tick;
    chk_res("tileB", 24'd22, 24'd22, 24'd22, 24'd22);
    drive(8'd9, 8'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    tick;
    drive(8'd2, 8'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    tick;
    chk_res("first_clears", 24'd4, 24'd4, 24'd4, 24'd4);
    drive(8'd2, 8'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick;
    for (int g = 0; g < 4; g++) chk("pre_skew_err", 24'(err[g]), 24'd0);
    drive(8'd50, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    for (int g = 0; g < 4; g++) chk("skew_err", 24'(err[g]), 24'd1);
    drive(8'd1, 8'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick;
    chk_res("skew_acc", 24'd5, 24'd5, 24'd5, 24'd5);
    drive(8'd7, 8'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    tick;
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick;
    chk_zero_state("mid_rst");
    rst = 1'b0;
    drive(8'd1, 8'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick;
    chk_res("rst_discard", 24'd1, 24'd1, 24'd1, 24'd1);
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    se = 1'b1; res_in = 24'd100; rvi = 1'b1;
    tick;
    chk_res("drain", 24'd100, 24'd100, 24'd100, 24'd100);
    chk("drain_rv", 24'(rv[3]), 24'd1);
    res_in = 24'd0; rvi = 1'b0;
    tick;
    chk_res("drain_empty", 24'd0, 24'd0, 24'd0, 24'd0);
    chk("drain_empty_rv", 24'(rv[1]), 24'd0);
    for (int g = 0; g < 4; g++) chk("pre_coll_err", 24'(err[g]), 24'd0);
    res_in = 24'd100; rvi = 1'b1;
    drive(8'd3, 8'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    tick;
    chk_res("collision", 24'd9, 24'd9, 24'd9, 24'd9);
    for (int g = 0; g < 4; g++) chk("coll_err", 24'(err[g]), 24'd1);
    se = 1'b0; rvi = 1'b0; res_in = 24'd55;
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick;
    chk_res("idle_hold", 24'd9, 24'd9, 24'd9, 24'd9);
    chk("idle_rv", 24'(rv[0]), 24'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
